// File: rtl/pl_pkg.sv
// Shared types and constants for the program loader: FSM states, frame header,
// and the largest payload the program ram can hold.
package pl_pkg;

  localparam int          PL_ADR_W  = 4;
  localparam int          PL_DATA_W = 8;
  localparam logic [7:0]  HDR       = 8'hA5;
  localparam int          MAX_LEN   = 2 ** PL_ADR_W;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

endpackage

// File: rtl/pl_cksum.sv
// Modulo-2**W running sum of payload bytes; ok reports whether sum + chk wraps to zero.
module pl_cksum #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         add,
  input  logic [W-1:0] din,
  input  logic [W-1:0] chk,
  output logic [W-1:0] sum,
  output logic         ok
);

  logic [W-1:0] acc;
  logic [W-1:0] total;

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (add) begin
      acc <= acc + din;
    end
  end

  assign total = acc + chk;
  assign ok    = (total == '0);
  assign sum   = acc;

endmodule

// File: rtl/prog_loader.sv
// Fills the cpu program ram from a framed byte stream (HDR, LEN, payload, CHK)
// and keeps the cpu in reset until a frame with a good checksum has landed.
module prog_loader
  import pl_pkg::*;
#(
  parameter int         ADR_W  = PL_ADR_W,
  parameter int         DATA_W = PL_DATA_W,
  parameter logic [7:0] HDR_B  = HDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADR_W-1:0]  mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output state_e            dbg_state
);

  // Handshake: a byte moves when in_valid && in_ready at a rising edge; in_ready
  // then drops for one cycle, and the source must hold in_data while waiting.
  localparam int max_len = 2 ** ADR_W;

  state_e            state, state_n;
  logic [ADR_W:0]    cnt, cnt_n;
  logic [ADR_W:0]    len, len_n;
  logic              in_ready_n, mem_we_n, cpu_reset_n, busy_n, done_n, err_n;
  logic [ADR_W-1:0]  mem_adr_n;
  logic [DATA_W-1:0] mem_wdata_n;
  logic              accept;
  logic              ck_clr, ck_add, ck_ok;
  logic [DATA_W-1:0] ck_sum;
  logic              len_bad;

  assign accept    = in_valid && in_ready;
  assign len_bad   = (in_data == '0) || (int'(in_data) > max_len);
  assign dbg_state = state;

  pl_cksum #(.W(DATA_W)) u_cksum (
    .clk   (clk),
    .reset (reset),
    .clr   (ck_clr),
    .add   (ck_add),
    .din   (in_data),
    .chk   (in_data),
    .sum   (ck_sum),
    .ok    (ck_ok)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      len       <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_adr   <= '0;
      mem_wdata <= '0;
      cpu_reset <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      len       <= len_n;
      in_ready  <= in_ready_n;
      mem_we    <= mem_we_n;
      mem_adr   <= mem_adr_n;
      mem_wdata <= mem_wdata_n;
      cpu_reset <= cpu_reset_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    len_n       = len;
    in_ready_n  = !accept;
    mem_we_n    = 1'b0;
    mem_adr_n   = mem_adr;
    mem_wdata_n = mem_wdata;
    cpu_reset_n = cpu_reset;
    busy_n      = busy;
    done_n      = done;
    err_n       = err;
    ck_clr      = 1'b0;
    ck_add      = 1'b0;

    if (accept) begin
      case (state)
        // A header restarts loading from any resting state; the cpu goes back
        // into reset immediately because the ram is about to be overwritten.
        ST_IDLE, ST_RUN, ST_ERR: begin
          if (in_data == DATA_W'(HDR_B)) begin
            state_n     = ST_LEN;
            busy_n      = 1'b1;
            cpu_reset_n = 1'b0;
            done_n      = 1'b0;
            err_n       = 1'b0;
          end
        end
        ST_LEN: begin
          if (len_bad) begin
            state_n = ST_ERR;
            err_n   = 1'b1;
            busy_n  = 1'b0;
          end else begin
            state_n = ST_DATA;
            len_n   = in_data[ADR_W:0];
            cnt_n   = '0;
            ck_clr  = 1'b1;
          end
        end
        ST_DATA: begin
          mem_we_n    = 1'b1;
          mem_adr_n   = cnt[ADR_W-1:0];
          mem_wdata_n = in_data;
          ck_add      = 1'b1;
          cnt_n       = cnt + 1'b1;
          if (cnt_n == len) begin
            state_n = ST_CHK;
          end
        end
        ST_CHK: begin
          busy_n = 1'b0;
          if (ck_ok) begin
            state_n     = ST_RUN;
            cpu_reset_n = 1'b1;
            done_n      = 1'b1;
          end else begin
            state_n = ST_ERR;
            err_n   = 1'b1;
          end
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: frames are predicted whole (writes + outcome) before
// sending; a negedge monitor pops expected ram writes as they appear.
module tb_prog_loader;
  import pl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready, mem_we, cpu_reset, busy, done, err;
  logic [3:0] mem_adr;
  logic [7:0] mem_wdata;
  state_e     dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;

  logic [11:0] exp_q[$];
  logic [11:0] exp_e;
  logic [7:0]  exp_mem [16];
  logic        written [16];
  logic [7:0]  ram [16];
  logic        exp_done, exp_err;

  prog_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // clock / reset / ram
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_we) ram[mem_adr] <= mem_wdata;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every ram write must be the next expected one and
  // must appear in the cycle right after the accepting edge
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {20'd0, mem_adr, mem_wdata}, 32'hFFFF_FFFF);
      end else begin
        exp_e = exp_q.pop_front();
        check("write_adr_data", {20'd0, mem_adr, mem_wdata}, {20'd0, exp_e});
        check("write_latency", cyc, acc_cyc);
      end
    end
  end

  // driver: called at a negedge, returns at the negedge after acceptance
  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    check("ready_drop", in_ready, 0);
  endtask

  task automatic send_garbage(input int n);
    logic [7:0] g;
    for (int i = 0; i < n; i++) begin
      g = 8'($urandom_range(0, 255));
      if (g == HDR) g = 8'h00;
      send_byte(g);
    end
  endtask

  // reference model: whole-frame prediction from the frame bytes alone
  task automatic model_frame(input logic [7:0] f[$]);
    int         l;
    logic [7:0] s;
    l = int'(f[1]);
    if (l == 0 || l > 16) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
    end else begin
      s = 8'd0;
      for (int i = 0; i < l; i++) begin
        exp_q.push_back({4'(i), f[2+i]});
        exp_mem[i] = f[2+i];
        written[i] = 1'b1;
        s = s + f[2+i];
      end
      s = s + f[2+l];
      exp_done = (s == 8'd0);
      exp_err  = (s != 8'd0);
    end
  endtask

  task automatic run_frame(input logic [7:0] f[$], input bit skip_hdr);
    model_frame(f);
    for (int i = (skip_hdr ? 1 : 0); i < f.size(); i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_byte(f[i]);
    end
    check("frame_done", done, exp_done);
    check("frame_err", err, exp_err);
    check("frame_cpu_reset", cpu_reset, exp_done);
    check("frame_busy", busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {in_ready, mem_we, cpu_reset, busy, done, err}, 0);
    check({tag, "_adr_wdata"}, {mem_adr, mem_wdata}, 0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  logic [7:0] fr[$];

  initial begin
    for (int i = 0; i < 16; i++) begin
      exp_mem[i] = 8'h00;
      written[i] = 1'b0;
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // reset held 3 cycles
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", in_ready, 1);
    check("cpu_reset_after_reset", cpu_reset, 0);

    // good 3-byte frame
    fr = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
    run_frame(fr, 1'b0);
    @(negedge clk);
    check("cpu_fetch_adr0", ram[0], 8'h11);

    // bad checksum, then length errors
    fr = {8'hA5, 8'h02, 8'h01, 8'h02, 8'h00};
    run_frame(fr, 1'b0);
    fr = {8'hA5, 8'h00};
    run_frame(fr, 1'b0);
    fr = {8'hA5, 8'h11};
    run_frame(fr, 1'b0);

    // full-depth frame, then header in RUN
    fr = {8'hA5, 8'h10};
    for (int i = 0; i < 16; i++) fr.push_back(8'(i));
    fr.push_back(8'h88);
    run_frame(fr, 1'b0);
    send_byte(HDR);
    check("restart_cpu_reset", cpu_reset, 0);
    check("restart_busy", busy, 1);
    check("restart_done", done, 0);
    fr = {8'hA5, 8'h01, 8'h5A, 8'hA6};
    run_frame(fr, 1'b1);

    // reset mid-frame after 2 of 4 payload bytes
    exp_q.push_back({4'd0, 8'hC1});
    exp_q.push_back({4'd1, 8'hC2});
    exp_mem[0] = 8'hC1;
    exp_mem[1] = 8'hC2;
    send_byte(HDR);
    send_byte(8'h04);
    send_byte(8'hC1);
    send_byte(8'hC2);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_ready", in_ready, 1);
    send_byte(8'h00);
    send_byte(8'hFF);
    check("garbage_ignored_busy", busy, 0);
    check("garbage_cpu_reset", cpu_reset, 0);
    fr = {8'hA5, 8'h02, 8'h10, 8'h20, 8'hD0};
    run_frame(fr, 1'b0);

    // randomized frames with garbage between them
    for (int n = 0; n < 12; n++) begin
      int         l, kind;
      logic [7:0] s;
      send_garbage($urandom_range(0, 2));
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        fr = {HDR, ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255))};
      end else begin
        l  = $urandom_range(1, 16);
        fr = {HDR, 8'(l)};
        s  = 8'd0;
        for (int i = 0; i < l; i++) begin
          fr.push_back(8'($urandom_range(0, 255)));
          s = s + fr[2+i];
        end
        s = 8'd0 - s;
        if (kind < 3) s = s + 8'($urandom_range(1, 255));
        fr.push_back(s);
      end
      run_frame(fr, 1'b0);
    end

    repeat (4) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    for (int i = 0; i < 16; i++) begin
      if (written[i]) check("ram_image", ram[i], exp_mem[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
